multicycle_ctrl_unit: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the 16-bit datapath unit.
- Consumes the datapath's 4-bit opcode and sequences one instruction over 3–5 clocks.
- Drives all datapath control inputs, plus a PC-advance strobe, so that register-file, memory and PC updates happen only in their designated cycles.
- Halts on illegal opcodes.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/multicycle_ctrl_unit_decode.sv | 53 +++++
 rtl/multicycle_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// opcodes, FSM states, ALU classes and the decode bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_DP_LO = 4'b0010;
  localparam logic [3:0] OP_DP_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1101;

  localparam logic [1:0] ALU_OP_DP  = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_MEM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_JMP,
    CLS_ILL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       is_illegal;
  } dec_t;

  // Last cycle of an instruction: the PC advances here.
  function automatic logic is_final(
    input state_e s,
    input cls_e   c
  );
    return (s == S_EXEC && (c == CLS_BEQ || c == CLS_BNE ||
                            c == CLS_JMP)) ||
           (s == S_MEM && c == CLS_SW) ||
           (s == S_WB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_decode.sv
// ctrl_decode: opcode -> instruction class and level controls.
// Ports: op_i (4-bit opcode), dec_o (decode bundle).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o            = '0;
    dec_o.cls        = CLS_ILL;
    dec_o.is_illegal = 1'b1;
    unique case (1'b1)
      (op_i == OP_LW): begin
        dec_o.cls        = CLS_LW;
        dec_o.alu_op     = ALU_OP_MEM;
        dec_o.alu_src    = 1'b1;
        dec_o.mem_to_reg = 1'b1;
        dec_o.is_illegal = 1'b0;
      end
      (op_i == OP_SW): begin
        dec_o.cls        = CLS_SW;
        dec_o.alu_op     = ALU_OP_MEM;
        dec_o.alu_src    = 1'b1;
        dec_o.is_illegal = 1'b0;
      end
      (op_i >= OP_DP_LO && op_i <= OP_DP_HI): begin
        dec_o.cls        = CLS_R;
        dec_o.alu_op     = ALU_OP_DP;
        dec_o.reg_dst    = 1'b1;
        dec_o.is_illegal = 1'b0;
      end
      (op_i == OP_BEQ): begin
        dec_o.cls        = CLS_BEQ;
        dec_o.alu_op     = ALU_OP_BR;
        dec_o.is_illegal = 1'b0;
      end
      (op_i == OP_BNE): begin
        dec_o.cls        = CLS_BNE;
        dec_o.alu_op     = ALU_OP_BR;
        dec_o.is_illegal = 1'b0;
      end
      (op_i == OP_JMP): begin
        dec_o.cls        = CLS_JMP;
        dec_o.alu_op     = ALU_OP_DP;
        dec_o.is_illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle control FSM for the 16-bit datapath; registered Moore
// outputs. Inputs clk, rst_n, run, opcode; outputs datapath controls,
// pc_en/instr_done strobes, sticky illegal, state_dbg.
// CTRL_PERF_CNT_EN adds retired_cnt and cycle_cnt outputs.
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int PERF_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                jump,
  output logic                beq,
  output logic                bne,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                pc_en,
  output logic                instr_done,
  output logic                illegal,
  output logic [2:0]          state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]   retired_cnt,
  output logic [PERF_W-1:0]   cycle_cnt
`endif
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  dec_t       dec;
  logic       act;

  logic jump_q, beq_q, bne_q, mrd_q, mwr_q;
  logic asrc_q, rdst_q, m2r_q, rwr_q, pc_q, ill_q;
  logic [1:0] aop_q;

  // The opcode is captured leaving FETCH; decoding the incoming value
  // lets DECODE's registered controls be ready on entry.
  assign op_d = (state_q == S_FETCH) ? opcode : op_q;

  ctrl_decode u_dec (
    .op_i  (op_d),
    .dec_o (dec)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec.is_illegal ? S_HALT : S_EXEC;
      S_EXEC, S_MEM, S_WB: begin
        if (is_final(state_q, dec.cls))
          state_d = run ? S_FETCH : S_IDLE;
        else if (state_q == S_EXEC &&
                 (dec.cls == CLS_LW || dec.cls == CLS_SW))
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Controls are live only while an instruction is in flight.
  assign act = !dec.is_illegal &&
               (state_d == S_DECODE || state_d == S_EXEC ||
                state_d == S_MEM    || state_d == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      jump_q  <= 1'b0;
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      asrc_q  <= 1'b0;
      rdst_q  <= 1'b0;
      m2r_q   <= 1'b0;
      rwr_q   <= 1'b0;
      aop_q   <= '0;
      pc_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      aop_q   <= act ? dec.alu_op : 2'b00;
      asrc_q  <= act && dec.alu_src;
      rdst_q  <= act && dec.reg_dst;
      m2r_q   <= act && dec.mem_to_reg;
      mrd_q   <= act && dec.cls == CLS_LW &&
                 (state_d == S_MEM || state_d == S_WB);
      mwr_q   <= act && dec.cls == CLS_SW && state_d == S_MEM;
      rwr_q   <= act && state_d == S_WB;
      jump_q  <= act && state_d == S_EXEC && dec.cls == CLS_JMP;
      beq_q   <= act && state_d == S_EXEC && dec.cls == CLS_BEQ;
      bne_q   <= act && state_d == S_EXEC && dec.cls == CLS_BNE;
      pc_q    <= act && is_final(state_d, dec.cls);
      ill_q   <= ill_q || (state_d == S_HALT);
    end
  end

  assign jump       = jump_q;
  assign beq        = beq_q;
  assign bne        = bne_q;
  assign mem_read   = mrd_q;
  assign mem_write  = mwr_q;
  assign alu_src    = asrc_q;
  assign reg_dst    = rdst_q;
  assign mem_to_reg = m2r_q;
  assign reg_write  = rwr_q;
  assign alu_op     = aop_q;
  assign pc_en      = pc_q;
  assign instr_done = pc_q;
  assign illegal    = ill_q;
  assign state_dbg  = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] ret_q, cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
      cyc_q <= '0;
    end else begin
      if (pc_q)
        ret_q <= ret_q + PERF_W'(1);
      if (state_q != S_IDLE && state_q != S_HALT)
        cyc_q <= cyc_q + PERF_W'(1);
    end
  end

  assign retired_cnt = ret_q;
  assign cycle_cnt   = cyc_q;
`else
  if (PERF_W > 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed self-checking bench for multicycle_ctrl_unit.
// Covers every instruction class, halt, async reset and run gating.
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n, run;
  logic [3:0] opcode;
  logic       jump, beq, bne, mem_read, mem_write;
  logic       alu_src, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_op;
  logic       pc_en, instr_done, illegal;
  logic [2:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [3:0] retired_cnt, cycle_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(.OPCODE_W(4), .PERF_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  // {state, jump beq bne mrd mwr asrc rdst m2r rwr, alu_op,
  //  pc_en, instr_done, illegal}
  logic [16:0] obs;
  assign obs = {state_dbg, jump, beq, bne, mem_read, mem_write,
                alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
                pc_en, instr_done, illegal};

  function automatic logic [16:0] ev(
    input logic [2:0] st,
    input logic [8:0] sb,
    input logic [1:0] aop,
    input logic       pc,
    input logic       ill
  );
    return {st, sb, aop, pc, pc, ill};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    run    = 1'b0;
    opcode = 4'b0000;
    #1;
    tests++;
    if (obs !== 17'h0) begin
      $display("FAIL reset_async: got %h want %h", obs, 17'h0);
      fails++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 17'h0) begin
      $display("FAIL reset_idle: got %h want %h", obs, 17'h0);
      fails++;
    end
  endtask

  // run dropped in EXEC; opcode garbage after FETCH must be ignored
  task automatic test_rtype();
    logic [16:0] e [5];
    e = '{ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000000100, 2'b00, 0, 0),
          ev(3, 9'b000000100, 2'b00, 0, 0),
          ev(5, 9'b000000101, 2'b00, 1, 0),
          ev(0, 9'b000000000, 2'b00, 0, 0)};
    do_reset();
    run    = 1'b1;
    opcode = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== e[i]) begin
        $display("FAIL rtype c%0d: got %h want %h", i, obs, e[i]);
        fails++;
      end
      if (i == 1) opcode = 4'b1111;
      if (i == 2) run = 1'b0;
    end
  endtask

  task automatic test_lw();
    logic [16:0] e [6];
    e = '{ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000001010, 2'b10, 0, 0),
          ev(3, 9'b000001010, 2'b10, 0, 0),
          ev(4, 9'b000101010, 2'b10, 0, 0),
          ev(5, 9'b000101011, 2'b10, 1, 0),
          ev(0, 9'b000000000, 2'b00, 0, 0)};
    do_reset();
    run    = 1'b1;
    opcode = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== e[i]) begin
        $display("FAIL lw c%0d: got %h want %h", i, obs, e[i]);
        fails++;
      end
      if (i == 1) run = 1'b0;
    end
  endtask

  task automatic test_sw();
    logic [16:0] e [5];
    e = '{ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000001000, 2'b10, 0, 0),
          ev(3, 9'b000001000, 2'b10, 0, 0),
          ev(4, 9'b000011000, 2'b10, 1, 0),
          ev(0, 9'b000000000, 2'b00, 0, 0)};
    do_reset();
    run    = 1'b1;
    opcode = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== e[i]) begin
        $display("FAIL sw c%0d: got %h want %h", i, obs, e[i]);
        fails++;
      end
      if (i == 1) run = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e [10];
    e = '{ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000000000, 2'b01, 0, 0),
          ev(3, 9'b010000000, 2'b01, 1, 0),
          ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000000000, 2'b01, 0, 0),
          ev(3, 9'b001000000, 2'b01, 1, 0),
          ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000000000, 2'b00, 0, 0),
          ev(3, 9'b100000000, 2'b00, 1, 0),
          ev(0, 9'b000000000, 2'b00, 0, 0)};
    do_reset();
    run    = 1'b1;
    opcode = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== e[i]) begin
        $display("FAIL b2b c%0d: got %h want %h", i, obs, e[i]);
        fails++;
      end
      if (i == 2) opcode = 4'b1100;
      if (i == 5) opcode = 4'b1101;
      if (i == 6) run = 1'b0;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e [8];
    e = '{ev(1, 9'b000000000, 2'b00, 0, 0),
          ev(2, 9'b000000000, 2'b00, 0, 0),
          ev(6, 9'b000000000, 2'b00, 0, 1),
          ev(6, 9'b000000000, 2'b00, 0, 1),
          ev(6, 9'b000000000, 2'b00, 0, 1),
          ev(6, 9'b000000000, 2'b00, 0, 1),
          ev(6, 9'b000000000, 2'b00, 0, 1),
          ev(6, 9'b000000000, 2'b00, 0, 1)};
    do_reset();
    run    = 1'b1;
    opcode = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== e[i]) begin
        $display("FAIL illegal c%0d: got %h want %h", i, obs, e[i]);
        fails++;
      end
      if (i == 1) opcode = 4'b0010;
      if (i == 3) run = 1'b0;
      if (i == 5) run = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 17'h0) begin
      $display("FAIL illegal_clr: got %h want %h", obs, 17'h0);
      fails++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b0;
  endtask

  task automatic test_reset_abort();
    do_reset();
    run    = 1'b1;
    opcode = 4'b0000;
    for (int i = 0; i < 4; i++) @(negedge clk);
    tests++;
    if (obs !== ev(4, 9'b000101010, 2'b10, 0, 0)) begin
      $display("FAIL abort_mem: got %h want %h", obs,
               ev(4, 9'b000101010, 2'b10, 0, 0));
      fails++;
    end
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 17'h0) begin
      $display("FAIL abort_async: got %h want %h", obs, 17'h0);
      fails++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== 17'h0) begin
        $display("FAIL abort_hold c%0d: got %h want %h", i, obs,
                 17'h0);
        fails++;
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 17'h0) begin
      $display("FAIL abort_idle: got %h want %h", obs, 17'h0);
      fails++;
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    tests++;
    if ({retired_cnt, cycle_cnt} !== 8'h00) begin
      $display("FAIL perf_rst: got %h want 00",
               {retired_cnt, cycle_cnt});
      fails++;
    end
    run    = 1'b1;
    opcode = 4'b0010;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 17) run = 1'b0;
    end
    tests++;
    if ({state_dbg, retired_cnt, cycle_cnt} !== {3'd0, 4'd5, 4'd4})
    begin
      $display("FAIL perf5: got st%0d r%0d c%0d want st0 r5 c4",
               state_dbg, retired_cnt, cycle_cnt);
      fails++;
    end
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 81; c++) begin
      @(negedge clk);
      if (c == 77) run = 1'b0;
    end
    tests++;
    if ({state_dbg, retired_cnt, cycle_cnt} !== {3'd0, 4'd4, 4'd0})
    begin
      $display("FAIL perf20: got st%0d r%0d c%0d want st0 r4 c0",
               state_dbg, retired_cnt, cycle_cnt);
      fails++;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
